// File: rtl/apb_pkg.sv
// Shared types for the APB4 master: FSM states, response record and a log2 helper.
package apb_pkg;

    // Upper bound on response data width; narrower buses zero-extend into it.
    localparam int unsigned RSP_DW = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [RSP_DW-1:0] rdata;
        logic              err;
        logic              timeout;
    } apb_rsp_t;

    function automatic int unsigned CLOG2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return r;
    endfunction

endpackage

// File: rtl/apb4_master_mux_if.sv
// Bridge request/response handshake plus the APB4 bus towards NUM_SLAVES peripherals.
interface apb4_master_mux_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SLAVES = 4
);
    logic                             req_valid_i;
    logic                             req_ready_o;
    logic [ADDR_WIDTH-1:0]            req_addr_i;
    logic                             req_write_i;
    logic [DATA_WIDTH-1:0]            req_wdata_i;
    logic [DATA_WIDTH/8-1:0]          req_strb_i;
    logic [2:0]                       req_prot_i;
    logic                             rsp_valid_o;
    logic [DATA_WIDTH-1:0]            rsp_rdata_o;
    logic                             rsp_err_o;
    logic                             rsp_timeout_o;
    logic [NUM_SLAVES-1:0]            psel;
    logic                             penable;
    logic                             pwrite;
    logic [ADDR_WIDTH-1:0]            paddr;
    logic [DATA_WIDTH-1:0]            pwdata;
    logic [DATA_WIDTH/8-1:0]          pstrb;
    logic [2:0]                       pprot;
    logic [NUM_SLAVES-1:0]            pready;
    logic [NUM_SLAVES-1:0]            pslverr;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata;

    modport master (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i, req_prot_i,
               pready, pslverr, prdata,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
               psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );

    modport slave (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i, req_prot_i,
               pready, pslverr, prdata,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
               psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );

endinterface

// File: rtl/apb_addr_decoder.sv
// Combinational address decode: slave index field above the per-slave region, anything higher is an error.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned NUM_SLAVES    = 4,
    parameter int unsigned SLV_ADDR_BITS = 12,
    parameter int unsigned IDX_W         = 2
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [NUM_SLAVES-1:0] o_sel,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_err
);
    localparam int unsigned FIELD_W = CLOG2(NUM_SLAVES);

    logic [ADDR_WIDTH-1:0] w_region;

    assign w_region = i_addr >> SLV_ADDR_BITS;
    assign o_err    = |(w_region >> FIELD_W);
    assign o_idx    = (NUM_SLAVES > 1) ? w_region[IDX_W-1:0] : '0;
    assign o_sel    = o_err ? '0 : (NUM_SLAVES'(1) << o_idx);

endmodule

// File: rtl/apb4_master_mux.sv
// APB4 master: one bridge transfer at a time, decoded to a psel line, with pready timeout abort.
module apb4_master_mux
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_SLAVES    = 4,
    parameter int unsigned SLV_ADDR_BITS = 12,
    parameter int unsigned TIMEOUT       = 16
) (
    input  logic              pclk,
    input  logic              preset,
    apb4_master_mux_if.master bus
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (NUM_SLAVES > 1) ? CLOG2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? CLOG2(TIMEOUT + 1) : 1;

    apb_state_e            r_state, w_state_nxt;
    logic [IDX_W-1:0]      r_idx, w_idx_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [NUM_SLAVES-1:0] r_psel, w_psel_nxt;
    logic                  r_penable, w_penable_nxt;
    logic                  r_pwrite, w_pwrite_nxt;
    logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
    logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nxt;
    logic [STRB_W-1:0]     r_pstrb, w_pstrb_nxt;
    logic [2:0]            r_pprot, w_pprot_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    apb_rsp_t              r_rsp, w_rsp_nxt;

    logic [NUM_SLAVES-1:0] w_dec_sel;
    logic [IDX_W-1:0]      w_dec_idx;
    logic                  w_dec_err;
    logic                  w_accept, w_pready, w_pslverr, w_timeout;
    logic [DATA_WIDTH-1:0] w_prdata;

    apb_addr_decoder #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .NUM_SLAVES   (NUM_SLAVES),
        .SLV_ADDR_BITS(SLV_ADDR_BITS),
        .IDX_W        (IDX_W)
    ) u_dec (
        .i_addr(bus.req_addr_i),
        .o_sel (w_dec_sel),
        .o_idx (w_dec_idx),
        .o_err (w_dec_err)
    );

    assign bus.req_ready_o = (r_state == IDLE) && !preset;
    assign w_accept        = bus.req_valid_i && bus.req_ready_o;

    // Only the latched slave's response lines matter for the whole transfer.
    assign w_pready  = bus.pready[r_idx];
    assign w_pslverr = bus.pslverr[r_idx];
    assign w_prdata  = bus.prdata[r_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_timeout = (TIMEOUT > 0) && !w_pready && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_pprot     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pstrb     <= w_pstrb_nxt;
            r_pprot     <= w_pprot_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp       <= w_rsp_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_dec_err) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = ACCESS;
            ACCESS:  if (w_pready || w_timeout) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Computes the next value of every registered output, so all APB pins come from flops.
    always_comb begin
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_pstrb_nxt     = r_pstrb;
        w_pprot_nxt     = r_pprot;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_nxt       = r_rsp;
        case (r_state)
            IDLE: begin
                if (w_accept && w_dec_err) begin
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_nxt.rdata   = '0;
                    w_rsp_nxt.err     = 1'b1;
                    w_rsp_nxt.timeout = 1'b0;
                end else if (w_accept) begin
                    w_idx_nxt    = w_dec_idx;
                    w_psel_nxt   = w_dec_sel;
                    w_pwrite_nxt = bus.req_write_i;
                    w_paddr_nxt  = bus.req_addr_i;
                    w_pprot_nxt  = bus.req_prot_i;
                    w_pwdata_nxt = bus.req_write_i ? bus.req_wdata_i : '0;
                    w_pstrb_nxt  = bus.req_write_i ? bus.req_strb_i : '0;
                end
            end
            SETUP: begin
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
            end
            ACCESS: begin
                if (w_pready) begin
                    w_psel_nxt        = '0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_nxt.err     = w_pslverr;
                    w_rsp_nxt.timeout = 1'b0;
                    w_rsp_nxt.rdata   = (!r_pwrite && !w_pslverr) ? RSP_DW'(w_prdata) : '0;
                end else if (w_timeout) begin
                    w_psel_nxt        = '0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_nxt.err     = 1'b1;
                    w_rsp_nxt.timeout = 1'b1;
                    w_rsp_nxt.rdata   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.psel          = r_psel;
    assign bus.penable       = r_penable;
    assign bus.pwrite        = r_pwrite;
    assign bus.paddr         = r_paddr;
    assign bus.pwdata        = r_pwdata;
    assign bus.pstrb         = r_pstrb;
    assign bus.pprot         = r_pprot;
    assign bus.rsp_valid_o   = r_rsp_valid;
    assign bus.rsp_rdata_o   = DATA_WIDTH'(r_rsp.rdata);
    assign bus.rsp_err_o     = r_rsp.err;
    assign bus.rsp_timeout_o = r_rsp.timeout;

endmodule

// File: tb/tb_apb4_master_mux.sv
// Bench for apb4_master_mux: directed vector table, random transfers against a decode/response model, reset sequences.
module tb_apb4_master_mux;
    localparam int AW = 32, DW = 32, NS = 4, SAB = 12, TO = 16;

    logic pclk = 1'b0;
    logic preset;
    always #5 pclk = ~pclk;

    apb4_master_mux_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus();

    apb4_master_mux #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SLV_ADDR_BITS(SAB), .TIMEOUT(TO)
    ) dut (
        .pclk  (pclk),
        .preset(preset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        logic        slverr;
        logic [31:0] rdata;
        logic [3:0]  exp_psel;
        logic        exp_err;
        logic        exp_to;
        logic [31:0] exp_rdata;
        logic        exp_dec;
    } vec_t;

    int    n_chk  = 0;
    int    n_pass = 0;
    string cur    = "";

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur, name, act, exp);
    endtask

    function automatic vec_t mkv(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                                 input logic [3:0] strb, input logic [2:0] prot, input int waits,
                                 input logic slverr, input logic [31:0] rdata, input logic [3:0] exp_psel,
                                 input logic exp_err, input logic exp_to, input logic [31:0] exp_rdata,
                                 input logic exp_dec);
        vec_t v;
        v.addr = addr; v.write = write; v.wdata = wdata; v.strb = strb; v.prot = prot;
        v.waits = waits; v.slverr = slverr; v.rdata = rdata; v.exp_psel = exp_psel;
        v.exp_err = exp_err; v.exp_to = exp_to; v.exp_rdata = exp_rdata; v.exp_dec = exp_dec;
        return v;
    endfunction

    // Reference: regions of 4 KiB, four slaves, anything at or beyond 16 KiB is unmapped.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int unsigned slot;
        logic        timed;
        r         = v;
        slot      = v.addr / (32'd1 << SAB);
        r.exp_dec = (slot >= NS);
        r.exp_psel = r.exp_dec ? 4'b0000 : 4'(1 << slot);
        timed     = !r.exp_dec && (v.waits >= TO);
        r.exp_err = r.exp_dec || timed || v.slverr;
        r.exp_to  = timed;
        r.exp_rdata = (!v.write && !r.exp_err) ? v.rdata : 32'h0;
        return r;
    endfunction

    // Entered and left just after a falling edge, so consecutive calls issue back-to-back requests.
    task automatic run(input vec_t v, input string tag);
        int unsigned slot;
        int          n_acc;
        cur  = tag;
        slot = (v.addr >> SAB) % NS;
        chk("req_ready_idle", bus.req_ready_o, 1);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = v.addr;
        bus.req_write_i = v.write;
        bus.req_wdata_i = v.wdata;
        bus.req_strb_i  = v.strb;
        bus.req_prot_i  = v.prot;
        @(posedge pclk); @(negedge pclk);
        bus.req_valid_i = 1'b0;
        if (v.exp_dec) begin
            chk("dec_rsp_valid", bus.rsp_valid_o, 1);
            chk("dec_rsp_err", bus.rsp_err_o, 1);
            chk("dec_rsp_to", bus.rsp_timeout_o, 0);
            chk("dec_rsp_rdata", bus.rsp_rdata_o, 0);
            chk("dec_psel", bus.psel, 0);
            chk("dec_ready", bus.req_ready_o, 1);
            return;
        end
        chk("setup_psel", bus.psel, v.exp_psel);
        chk("setup_penable", bus.penable, 0);
        chk("setup_paddr", bus.paddr, v.addr);
        chk("setup_pwrite", bus.pwrite, v.write);
        chk("setup_pprot", bus.pprot, v.prot);
        chk("setup_pwdata", bus.pwdata, v.write ? v.wdata : 32'h0);
        chk("setup_pstrb", bus.pstrb, v.write ? v.strb : 4'h0);
        chk("setup_rsp_valid", bus.rsp_valid_o, 0);
        n_acc = (v.waits < TO) ? v.waits + 1 : TO;
        for (int a = 0; a < n_acc; a++) begin
            @(posedge pclk); @(negedge pclk);
            chk("acc_penable", bus.penable, 1);
            chk("acc_psel", bus.psel, v.exp_psel);
            chk("acc_paddr", bus.paddr, v.addr);
            chk("acc_pwdata", bus.pwdata, v.write ? v.wdata : 32'h0);
            chk("acc_pstrb", bus.pstrb, v.write ? v.strb : 4'h0);
            chk("acc_rsp_valid", bus.rsp_valid_o, 0);
            chk("acc_ready", bus.req_ready_o, 0);
            bus.pready  = 4'($urandom) & ~(4'b0001 << slot);
            bus.pslverr = 4'($urandom);
            bus.prdata  = {$urandom, $urandom, $urandom, $urandom};
            if (a == v.waits) begin
                bus.pready[slot]            = 1'b1;
                bus.pslverr[slot]           = v.slverr;
                bus.prdata[slot*DW +: DW]   = v.rdata;
            end
        end
        @(posedge pclk); @(negedge pclk);
        bus.pready  = '0;
        bus.pslverr = '0;
        bus.prdata  = '0;
        chk("rsp_valid", bus.rsp_valid_o, 1);
        chk("rsp_err", bus.rsp_err_o, v.exp_err);
        chk("rsp_timeout", bus.rsp_timeout_o, v.exp_to);
        chk("rsp_rdata", bus.rsp_rdata_o, v.exp_rdata);
        chk("done_psel", bus.psel, 0);
        chk("done_penable", bus.penable, 0);
        chk("done_ready", bus.req_ready_o, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t tbl[10];
        vec_t v;
        preset          = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_write_i = 1'b0;
        bus.req_wdata_i = '0;
        bus.req_strb_i  = '0;
        bus.req_prot_i  = '0;
        bus.pready      = '0;
        bus.pslverr     = '0;
        bus.prdata      = '0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        cur = "reset";
        chk("psel", bus.psel, 0);
        chk("penable", bus.penable, 0);
        chk("pwrite", bus.pwrite, 0);
        chk("paddr", bus.paddr, 0);
        chk("pwdata", bus.pwdata, 0);
        chk("pstrb", bus.pstrb, 0);
        chk("pprot", bus.pprot, 0);
        chk("rsp_valid", bus.rsp_valid_o, 0);
        chk("rsp_rdata", bus.rsp_rdata_o, 0);
        chk("rsp_err", bus.rsp_err_o, 0);
        chk("rsp_timeout", bus.rsp_timeout_o, 0);
        chk("req_ready", bus.req_ready_o, 0);
        preset = 1'b0;
        @(posedge pclk); @(negedge pclk);

        //            addr          wr wdata         strb     prot    wt er rdata          psel     er to exp_rdata     dec
        tbl[0] = mkv(32'h0000_1010, 1, 32'hA5A5_A5A5, 4'hF,    3'b000, 0, 0, 32'h0,         4'b0010, 0, 0, 32'h0,        0);
        tbl[1] = mkv(32'h0000_3004, 0, 32'h1111_2222, 4'hF,    3'b010, 4, 0, 32'hDEAD_BEEF, 4'b1000, 0, 0, 32'hDEAD_BEEF, 0);
        tbl[2] = mkv(32'h0000_2000, 0, 32'h0,         4'h0,    3'b001, 1, 1, 32'h1234_5678, 4'b0100, 1, 0, 32'h0,        0);
        tbl[3] = mkv(32'h0001_0000, 0, 32'h0,         4'h0,    3'b000, 0, 0, 32'h0,         4'b0000, 1, 0, 32'h0,        1);
        tbl[4] = mkv(32'h0000_0FFC, 0, 32'h0,         4'hF,    3'b101, 15, 0, 32'hCAFE_F00D, 4'b0001, 0, 0, 32'hCAFE_F00D, 0);
        tbl[5] = mkv(32'h0000_3FFC, 1, 32'h5555_AAAA, 4'b0101, 3'b110, 16, 0, 32'h0,        4'b1000, 1, 1, 32'h0,        0);
        tbl[6] = mkv(32'h8000_0000, 1, 32'hFFFF_FFFF, 4'hF,    3'b000, 0, 0, 32'h0,         4'b0000, 1, 0, 32'h0,        1);
        tbl[7] = mkv(32'h0000_2100, 1, 32'h0BAD_F00D, 4'b0011, 3'b000, 2, 1, 32'h7777_7777, 4'b0100, 1, 0, 32'h0,        0);
        tbl[8] = mkv(32'h0000_4000, 0, 32'h0,         4'h0,    3'b000, 0, 0, 32'h9999_9999, 4'b0000, 1, 0, 32'h0,        1);
        tbl[9] = mkv(32'h0000_0000, 0, 32'hFFFF_FFFF, 4'hF,    3'b111, 0, 0, 32'h0F0F_F0F0, 4'b0001, 0, 0, 32'h0F0F_F0F0, 0);
        for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            v.addr   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 16383));
            v.write  = 1'($urandom);
            v.wdata  = $urandom;
            v.strb   = 4'($urandom);
            v.prot   = 3'($urandom);
            v.waits  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            v.slverr = ($urandom_range(0, 3) == 0);
            v.rdata  = $urandom;
            v = model(v);
            run(v, $sformatf("rnd%0d", i));
        end

        // Reset while waiting in ACCESS: transfer dropped, no response afterwards.
        cur = "midreset";
        chk("ready", bus.req_ready_o, 1);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h0000_1000;
        bus.req_write_i = 1'b0;
        @(posedge pclk); @(negedge pclk);
        bus.req_valid_i = 1'b0;
        chk("setup_psel", bus.psel, 4'b0010);
        @(posedge pclk); @(negedge pclk);
        chk("acc_penable", bus.penable, 1);
        preset = 1'b1;
        @(posedge pclk); @(negedge pclk);
        chk("psel", bus.psel, 0);
        chk("penable", bus.penable, 0);
        chk("rsp_valid", bus.rsp_valid_o, 0);
        chk("ready_in_reset", bus.req_ready_o, 0);
        preset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); @(negedge pclk);
            chk("post_rsp_valid", bus.rsp_valid_o, 0);
            chk("post_psel", bus.psel, 0);
        end
        chk("post_ready", bus.req_ready_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
